// File: rtl/md_scheduler.sv
// md_scheduler: sequences the shared multiply/divide unit and owns the HI/LO
// registers. One MDU op is accepted from E, held for a fixed latency, then
// committed. Raises md_stall for MDU-class D instructions while occupied.
module md_scheduler #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_md_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    input  logic        D_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_is_uns;
    logic [31:0]      r_rs;
    logic [31:0]      r_rt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_idle;
    logic        w_mdu_start;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_commit;
    logic [63:0] w_rs_ext;
    logic [63:0] w_rt_ext;
    logic [63:0] w_prod;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic        w_div_zero;
    logic [31:0] w_rt_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Ops 6/7 have E_md_op[2] set with op[1:0] = 2/3, so only 4 and 5 are moves.
    assign w_idle      = (r_state == S_IDLE);
    assign w_mdu_start = E_md_start & w_idle & ~E_md_op[2];
    assign w_mthi      = E_md_start & w_idle & (E_md_op == 3'd4);
    assign w_mtlo      = E_md_start & w_idle & (E_md_op == 3'd5);
    assign w_commit    = (r_state == S_BUSY) & (r_cnt == '0);

    // Product: two's-complement low 64 bits are the signed product when the
    // operands are sign-extended, the unsigned product when zero-extended.
    assign w_rs_ext = r_is_uns ? {32'b0, r_rs} : {{32{r_rs[31]}}, r_rs};
    assign w_rt_ext = r_is_uns ? {32'b0, r_rt} : {{32{r_rt[31]}}, r_rt};
    assign w_prod   = w_rs_ext * w_rt_ext;

    // Division on magnitudes; signs restored afterwards. The 0x80000000/-1
    // case wraps back to 0x80000000 naturally, and a zero divisor is replaced
    // by 1 only to keep the divider defined (its result is never committed).
    assign w_rs_neg   = ~r_is_uns & r_rs[31];
    assign w_rt_neg   = ~r_is_uns & r_rt[31];
    assign w_rs_mag   = w_rs_neg ? (32'd0 - r_rs) : r_rs;
    assign w_rt_mag   = w_rt_neg ? (32'd0 - r_rt) : r_rt;
    assign w_div_zero = (r_rt == 32'd0);
    assign w_rt_den   = w_div_zero ? 32'd1 : w_rt_mag;
    assign w_q_mag    = w_rs_mag / w_rt_den;
    assign w_r_mag    = w_rs_mag % w_rt_den;
    assign w_quot     = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign w_res_hi = r_is_div ? w_rem  : w_prod[63:32];
    assign w_res_lo = r_is_div ? w_quot : w_prod[31:0];

    // Control FSM: accept an op in IDLE, count down the latency, return to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_is_uns <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_mdu_start) begin
                        r_state  <= S_BUSY;
                        r_busy   <= 1'b1;
                        r_cnt    <= E_md_op[1] ? DIV_LOAD : MULT_LOAD;
                        r_is_div <= E_md_op[1];
                        r_is_uns <= E_md_op[0];
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand latches: captured once at op acceptance, stable for the whole op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs <= 32'd0;
            r_rt <= 32'd0;
        end else if (w_mdu_start) begin
            r_rs <= E_rs_data;
            r_rt <= E_rt_data;
        end
    end

    // HI/LO: commit at the final busy edge (skipped on divide-by-zero), or direct moves in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (!(r_is_div && w_div_zero)) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (w_mthi) begin
            r_hi <= E_rs_data;
        end else if (w_mtlo) begin
            r_lo <= E_rs_data;
        end
    end

    assign busy     = r_busy;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign md_stall = D_md_use & (r_busy | (E_md_start & ~E_md_op[2]));

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed and randomized stimulus for md_scheduler, checked
// every cycle against a behavioural model of the MDU sequencing rules.
module tb_md_scheduler;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_md_start = 1'b0;
    logic [2:0]  E_md_op = 3'd7;
    logic [31:0] E_rs_data = 32'd0;
    logic [31:0] E_rt_data = 32'd0;
    logic        D_md_use = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    md_scheduler #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_md_start(E_md_start),
        .E_md_op   (E_md_op),
        .E_rs_data (E_rs_data),
        .E_rt_data (E_rt_data),
        .D_md_use  (D_md_use),
        .busy      (busy),
        .md_stall  (md_stall),
        .HI        (HI),
        .LO        (LO)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: cycles remaining, and the result waiting to land.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_wr = 1'b0;
    int          m_left = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Architectural result of an MDU op, straight from the arithmetic rules.
    function automatic void mdu_result(input logic [2:0] op, input logic [31:0] rs,
                                       input logic [31:0] rt, output logic [31:0] hi,
                                       output logic [31:0] lo, output bit wr);
        longint a, b, q, r;
        logic [63:0] p;
        hi = 32'd0;
        lo = 32'd0;
        wr = 1'b1;
        case (op)
            3'd0: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                p = 64'(a * b);
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd1: begin
                p = {32'b0, rs} * {32'b0, rt};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (op == 3'd2) begin
                    a = longint'($signed(rs));
                    b = longint'($signed(rt));
                end else begin
                    a = longint'({32'b0, rs});
                    b = longint'({32'b0, rt});
                end
                if (b == 0) begin
                    wr = 1'b0;
                end else begin
                    q = a / b;
                    r = a % b;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_left = 0;
            p_wr = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (E_md_start) begin
            if (E_md_op <= 3'd3) begin
                mdu_result(E_md_op, E_rs_data, E_rt_data, p_hi, p_lo, p_wr);
                m_left = (E_md_op <= 3'd1) ? MULT_CYC : DIV_CYC;
            end else if (E_md_op == 3'd4) begin
                m_hi = E_rs_data;
            end else if (E_md_op == 3'd5) begin
                m_lo = E_rs_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("md_stall", 32'(md_stall),
                  32'(D_md_use && ((m_left > 0) || (E_md_start && E_md_op <= 3'd3))));
            check("HI", HI, m_hi);
            check("LO", LO, m_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic use_d);
        E_md_start = 1'b1;
        E_md_op    = op;
        E_rs_data  = rs;
        E_rt_data  = rt;
        D_md_use   = use_d;
        #1;
        check("stall_start", 32'(md_stall), 32'(use_d && op <= 3'd3));
        step();
        E_md_start = 1'b0;
        E_md_op    = 3'd7;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy && c < 60) begin
            c++;
            step();
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        reset = 1'b1;
        chk_en = 1'b1;
        step();

        // Signed multiply with a dependent D instruction stalled throughout.
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_idle(c);
        check("mult_cycles", 32'(c), 32'd5);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFFA);
        check("stall_after", 32'(md_stall), 32'd0);
        D_md_use = 1'b0;

        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_idle(c);
        check("multu_cycles", 32'(c), 32'd5);
        check("multu_HI", HI, 32'h0000_0001);
        check("multu_LO", LO, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(c);
        check("div_cycles", 32'(c), 32'd10);
        check("div_LO", LO, 32'hFFFF_FFFD);
        check("div_HI", HI, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(c);
        check("divovf_LO", LO, 32'h8000_0000);
        check("divovf_HI", HI, 32'h0000_0000);

        // Divide by zero keeps HI/LO but still occupies the unit.
        issue(3'd4, 32'h11, 32'd0, 1'b0);
        issue(3'd5, 32'h22, 32'd0, 1'b0);
        issue(3'd3, 32'd77, 32'd0, 1'b0);
        wait_idle(c);
        check("divz_cycles", 32'(c), 32'd10);
        check("divz_HI", HI, 32'h11);
        check("divz_LO", LO, 32'h22);

        issue(3'd5, 32'h1234, 32'd0, 1'b0);
        check("mtlo_LO", LO, 32'h1234);
        check("mtlo_busy", 32'(busy), 32'd0);

        // Starts while busy are ignored.
        issue(3'd0, 32'd7, 32'd9, 1'b0);
        E_md_start = 1'b1;
        E_md_op    = 3'd4;
        E_rs_data  = 32'hDEAD;
        step();
        E_md_op    = 3'd2;
        E_rt_data  = 32'd1;
        step();
        E_md_start = 1'b0;
        E_md_op    = 3'd7;
        wait_idle(c);
        check("ign_cycles", 32'(c), 32'd3);
        check("ign_HI", HI, 32'd0);
        check("ign_LO", LO, 32'd63);

        // Asynchronous reset during the third busy cycle of a divide.
        issue(3'd4, 32'd5, 32'd0, 1'b0);
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_HI", HI, 32'd0);
        check("arst_LO", LO, 32'd0);
        step();
        reset = 1'b1;
        step();
        issue(3'd0, 32'd2, 32'd3, 1'b0);
        wait_idle(c);
        check("post_cycles", 32'(c), 32'd5);
        check("post_LO", LO, 32'd6);
        check("post_HI", HI, 32'd0);

        // Randomized traffic, including starts while busy and unused opcodes.
        for (int i = 0; i < 3000; i++) begin
            E_md_start = ($urandom % 3) == 0;
            E_md_op    = 3'($urandom % 8);
            E_rs_data  = rand_val();
            E_rt_data  = rand_val();
            D_md_use   = 1'($urandom % 2);
            step();
        end
        E_md_start = 1'b0;
        E_md_op    = 3'd7;
        wait_idle(c);
        step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
